// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a binary value source and the
// sequential BCD converter.
interface bin_to_bcd_seq_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [BIN_W-1:0]      binIn;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcdOut;
   logic                  ovf;

   modport master (
      output start, binIn,
      input  busy, done, bcdOut, ovf
   );

   modport slave (
      input  start, binIn,
      output busy, done, bcdOut, ovf
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one iteration per clock.
// Results saturate to all 9s when the value does not fit in DIGITS digits.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input logic               clk,
   input logic               rstN,
   bin_to_bcd_seq_if.slave   bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   if ((BIN_W < 1) || (BIN_W > 16) || (DIGITS < 1) || (DIGITS > 5)) begin : g_bad_params
      $error("bin_to_bcd_seq: BIN_W must be 1..16 and DIGITS 1..5");
   end

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   shift_q, shift_d, shift_sh;
   logic [BCD_W-1:0]   scratch_q, scratch_d, scratch_sh, adj;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sticky_q, sticky_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;
   logic               shift_out;

   // Digits are adjusted independently; a digit >= 5 never exceeds 4'hC after +3.
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                        : scratch_q[4*i +: 4];
      end
      {shift_out, scratch_sh} = {adj, shift_q[BIN_W-1]};
      shift_sh = shift_q << 1;
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      sticky_d  = sticky_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d   = bus.binIn;
               scratch_d = '0;
               sticky_d  = 1'b0;
               cnt_d     = CNT_W'(BIN_W);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            shift_d   = shift_sh;
            scratch_d = scratch_sh;
            sticky_d  = sticky_q | shift_out;
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               ovf_d   = sticky_d;
               bcd_d   = sticky_d ? {DIGITS{4'h9}} : scratch_sh;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         sticky_q  <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         sticky_q  <= sticky_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy   = (state_q == SHIFT);
   assign bus.done   = done_q;
   assign bus.bcdOut = bcd_q;
   assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq: three instances cover the default,
// overflowing (DIGITS=2) and widest (BIN_W=16, DIGITS=5) configurations.
module tb_bin_to_bcd_seq;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) a_if ();
   bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) b_if ();
   bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) c_if ();

   bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut_a (.clk(clk), .rstN(rstN), .bus(a_if.slave));
   bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(2)) dut_b (.clk(clk), .rstN(rstN), .bus(b_if.slave));
   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_c (.clk(clk), .rstN(rstN), .bus(c_if.slave));

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      vectors++;
      if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", a_if.busy, a_if.done);
      end
      vectors++;
      if (a_if.bcdOut !== 12'h000 || a_if.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_data: bcd=%h ovf=%b expected 000 0", a_if.bcdOut, a_if.ovf);
      end
      vectors++;
      if (c_if.bcdOut !== 20'h00000 || c_if.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_wide: bcd=%h busy=%b expected 00000 0", c_if.bcdOut, c_if.busy);
      end
      rstN = 1'b1;
      tick();
   endtask

   task automatic test_max_value();
      a_if.binIn = 8'd255;
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (a_if.busy !== 1'b1 || a_if.done !== 1'b0) begin
            miscompares++;
            $display("FAIL max_busy[%0d]: busy=%b done=%b expected 1 0", k, a_if.busy, a_if.done);
         end
         tick();
      end
      vectors++;
      if (a_if.done !== 1'b1 || a_if.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL max_done: done=%b busy=%b expected 1 0", a_if.done, a_if.busy);
      end
      vectors++;
      if (a_if.bcdOut !== 12'h255 || a_if.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL max_result: bcd=%h ovf=%b expected 255 0", a_if.bcdOut, a_if.ovf);
      end
      tick();
      vectors++;
      if (a_if.done !== 1'b0) begin
         miscompares++;
         $display("FAIL max_done_pulse: done=%b expected 0", a_if.done);
      end
   endtask

   task automatic test_back_to_back();
      a_if.binIn = 8'd0;
      a_if.start = 1'b1;
      tick();
      a_if.binIn = 8'd99;
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (a_if.busy !== 1'b1 || a_if.bcdOut !== 12'h255) begin
            miscompares++;
            $display("FAIL b2b_hold1[%0d]: busy=%b bcd=%h expected 1 255", k, a_if.busy, a_if.bcdOut);
         end
         tick();
      end
      vectors++;
      if (a_if.done !== 1'b1 || a_if.bcdOut !== 12'h000 || a_if.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_zero: done=%b bcd=%h ovf=%b expected 1 000 0", a_if.done, a_if.bcdOut, a_if.ovf);
      end
      tick();
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (a_if.busy !== 1'b1 || a_if.done !== 1'b0 || a_if.bcdOut !== 12'h000) begin
            miscompares++;
            $display("FAIL b2b_hold2[%0d]: busy=%b done=%b bcd=%h expected 1 0 000",
                     k, a_if.busy, a_if.done, a_if.bcdOut);
         end
         tick();
      end
      vectors++;
      if (a_if.done !== 1'b1 || a_if.bcdOut !== 12'h099) begin
         miscompares++;
         $display("FAIL b2b_99: done=%b bcd=%h expected 1 099", a_if.done, a_if.bcdOut);
      end
      a_if.start = 1'b0;
      tick();
      vectors++;
      if (a_if.done !== 1'b0 || a_if.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_idle: done=%b busy=%b expected 0 0", a_if.done, a_if.busy);
      end
   endtask

   task automatic test_start_while_busy();
      int dones;
      dones = 0;
      a_if.binIn = 8'd128;
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      tick();
      tick();
      a_if.binIn = 8'd7;
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (a_if.done === 1'b1) dones++;
         tick();
      end
      vectors++;
      if (dones !== 1) begin
         miscompares++;
         $display("FAIL busy_ignore_count: done pulses=%0d expected 1", dones);
      end
      vectors++;
      if (a_if.bcdOut !== 12'h128 || a_if.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_ignore_value: bcd=%h busy=%b expected 128 0", a_if.bcdOut, a_if.busy);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      dones = 0;
      a_if.binIn = 8'd200;
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      tick();
      tick();
      tick();
      rstN = 1'b0;
      #1;
      vectors++;
      if (a_if.busy !== 1'b0 || a_if.done !== 1'b0 || a_if.bcdOut !== 12'h000 || a_if.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_async: busy=%b done=%b bcd=%h ovf=%b expected 0 0 000 0",
                  a_if.busy, a_if.done, a_if.bcdOut, a_if.ovf);
      end
      tick();
      rstN = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (a_if.done === 1'b1 || a_if.busy === 1'b1) dones++;
         tick();
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++;
         $display("FAIL mid_reset_abort: busy/done cycles=%0d expected 0", dones);
      end
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      repeat (8) tick();
      vectors++;
      if (a_if.done !== 1'b1 || a_if.bcdOut !== 12'h200 || a_if.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_redo: done=%b bcd=%h ovf=%b expected 1 200 0",
                  a_if.done, a_if.bcdOut, a_if.ovf);
      end
      tick();
   endtask

   task automatic test_overflow();
      b_if.binIn = 8'd255;
      b_if.start = 1'b1;
      tick();
      b_if.start = 1'b0;
      repeat (8) tick();
      vectors++;
      if (b_if.done !== 1'b1 || b_if.ovf !== 1'b1 || b_if.bcdOut !== 8'h99) begin
         miscompares++;
         $display("FAIL ovf_saturate: done=%b ovf=%b bcd=%h expected 1 1 99",
                  b_if.done, b_if.ovf, b_if.bcdOut);
      end
      b_if.binIn = 8'd42;
      b_if.start = 1'b1;
      tick();
      b_if.start = 1'b0;
      vectors++;
      if (b_if.ovf !== 1'b1 || b_if.bcdOut !== 8'h99) begin
         miscompares++;
         $display("FAIL ovf_hold: ovf=%b bcd=%h expected 1 99", b_if.ovf, b_if.bcdOut);
      end
      repeat (8) tick();
      vectors++;
      if (b_if.done !== 1'b1 || b_if.ovf !== 1'b0 || b_if.bcdOut !== 8'h42) begin
         miscompares++;
         $display("FAIL ovf_clear: done=%b ovf=%b bcd=%h expected 1 0 42",
                  b_if.done, b_if.ovf, b_if.bcdOut);
      end
      tick();
   endtask

   task automatic test_wide();
      c_if.binIn = 16'd65535;
      c_if.start = 1'b1;
      tick();
      c_if.start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         vectors++;
         if (c_if.busy !== 1'b1 || c_if.done !== 1'b0) begin
            miscompares++;
            $display("FAIL wide_busy[%0d]: busy=%b done=%b expected 1 0", k, c_if.busy, c_if.done);
         end
         tick();
      end
      vectors++;
      if (c_if.done !== 1'b1 || c_if.bcdOut !== 20'h65535 || c_if.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL wide_result: done=%b bcd=%h ovf=%b expected 1 65535 0",
                  c_if.done, c_if.bcdOut, c_if.ovf);
      end
      tick();
   endtask

   initial begin
      a_if.start = 1'b0;
      a_if.binIn = '0;
      b_if.start = 1'b0;
      b_if.binIn = '0;
      c_if.start = 1'b0;
      c_if.binIn = '0;
      test_reset();
      test_max_value();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid();
      test_overflow();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
